// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle CPU control FSM: fetch, decode, ALU, load/store, branch, halt.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ir_1,
    input  logic [2:0] funct,
    input  logic       cc,
    input  logic       mem_ready,
    output logic       ldMDR,
    output logic       Tmdr,
    output logic       ldMAR,
    output logic       ldIR,
    output logic       Tlabel,
    output logic       ALUon,
    output logic       mm,
    output logic       ldALUreg,
    output logic       ldSP,
    output logic       ldPC,
    output logic       Tsp,
    output logic       Tpc,
    output logic       ldReg,
    output logic       Treg,
    output logic       ldFlag,
    output logic       pc_inc,
    output logic       mdr_bus,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       halted,
    output logic       illegal,
    output logic [2:0] fnSelect,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FA   = 4'd0,
        S_FM   = 4'd1,
        S_FI   = 4'd2,
        S_DEC  = 4'd3,
        S_EX   = 4'd4,
        S_WB   = 4'd5,
        S_MA   = 4'd6,
        S_MM   = 4'd7,
        S_SD   = 4'd8,
        S_MW   = 4'd9,
        S_BR   = 4'd10,
        S_HALT = 4'd11
    } state_t;

    localparam logic [3:0] OP_ALU0  = 4'b0000;
    localparam logic [3:0] OP_ALU1  = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b0011;
    localparam logic [3:0] OP_BRCC  = 4'b0100;
    localparam logic [3:0] OP_JUMP  = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FA;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d = S_FA;
        case (state_q)
            S_FA:   state_d = S_FM;
            S_FM:   state_d = mem_ready ? S_FI : S_FM;
            S_FI:   state_d = S_DEC;
            S_DEC: begin
                case (ir_1)
                    OP_ALU0, OP_ALU1:  state_d = S_EX;
                    OP_LOAD, OP_STORE: state_d = S_MA;
                    OP_BRCC:           state_d = cc ? S_BR : S_FA;
                    OP_JUMP:           state_d = S_BR;
                    OP_HALT:           state_d = S_HALT;
                    default:           state_d = S_FA;
                endcase
            end
            S_EX:   state_d = S_WB;
            S_WB:   state_d = S_FA;
            S_MA: begin
                if (ir_1 == OP_LOAD) begin
                    state_d = S_MM;
                end else if (ir_1 == OP_STORE) begin
                    state_d = S_SD;
                end else begin
                    state_d = S_FA;
                end
            end
            S_MM:   state_d = mem_ready ? S_WB : S_MM;
            S_SD:   state_d = S_MW;
            S_MW:   state_d = mem_ready ? S_FA : S_MW;
            S_BR:   state_d = S_FA;
            S_HALT: state_d = S_HALT;
            default: state_d = S_FA;
        endcase
    end

    // Outputs follow the state register; only ldMDR in read-wait states looks at mem_ready.
    always_comb begin
        ldMDR    = 1'b0;
        Tmdr     = 1'b0;
        ldMAR    = 1'b0;
        ldIR     = 1'b0;
        Tlabel   = 1'b0;
        ALUon    = 1'b0;
        mm       = 1'b0;
        ldALUreg = 1'b0;
        ldSP     = 1'b0;
        ldPC     = 1'b0;
        Tsp      = 1'b0;
        Tpc      = 1'b0;
        ldReg    = 1'b0;
        Treg     = 1'b0;
        ldFlag   = 1'b0;
        pc_inc   = 1'b0;
        mdr_bus  = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;
        fnSelect = 3'b000;
        case (state_q)
            S_FA: begin
                Tpc   = 1'b1;
                ldMAR = 1'b1;
            end
            S_FM, S_MM: begin
                mem_rd = 1'b1;
                ldMDR  = mem_ready;
            end
            S_FI: begin
                Tmdr   = 1'b1;
                ldIR   = 1'b1;
                pc_inc = 1'b1;
            end
            S_DEC: begin
                case (ir_1)
                    OP_ALU0, OP_ALU1, OP_LOAD, OP_STORE,
                    OP_BRCC, OP_JUMP, OP_HALT: illegal = 1'b0;
                    default:                   illegal = 1'b1;
                endcase
            end
            S_EX: begin
                ALUon    = 1'b1;
                fnSelect = funct;
                mm       = ir_1[0];
                ldALUreg = 1'b1;
                ldFlag   = 1'b1;
            end
            S_WB: begin
                ldReg = 1'b1;
                Tmdr  = (ir_1 == OP_LOAD);
            end
            S_MA: begin
                Tlabel = 1'b1;
                ldMAR  = 1'b1;
            end
            S_SD: begin
                Treg    = 1'b1;
                ldMDR   = 1'b1;
                mdr_bus = 1'b1;
            end
            S_MW: begin
                mem_wr = 1'b1;
            end
            S_BR: begin
                Tlabel = 1'b1;
                ldPC   = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized instruction stream against a per-instruction trace model with a scoreboard.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] ir_1 = 4'd0;
    logic [2:0] funct = 3'd0;
    logic       cc = 1'b0;
    logic       mem_ready = 1'b0;
    logic ldMDR, Tmdr, ldMAR, ldIR, Tlabel, ALUon, mm, ldALUreg, ldSP, ldPC, Tsp, Tpc;
    logic ldReg, Treg, ldFlag, pc_inc, mdr_bus, mem_rd, mem_wr, halted, illegal;
    logic [2:0] fnSelect;
    logic [3:0] state;

    control_unit dut (
        .clk(clk), .reset(reset), .ir_1(ir_1), .funct(funct), .cc(cc), .mem_ready(mem_ready),
        .ldMDR(ldMDR), .Tmdr(Tmdr), .ldMAR(ldMAR), .ldIR(ldIR), .Tlabel(Tlabel), .ALUon(ALUon),
        .mm(mm), .ldALUreg(ldALUreg), .ldSP(ldSP), .ldPC(ldPC), .Tsp(Tsp), .Tpc(Tpc),
        .ldReg(ldReg), .Treg(Treg), .ldFlag(ldFlag), .pc_inc(pc_inc), .mdr_bus(mdr_bus),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .illegal(illegal),
        .fnSelect(fnSelect), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] ST_FA = 4'd0, ST_FM = 4'd1, ST_FI = 4'd2, ST_DEC = 4'd3;
    localparam logic [3:0] ST_EX = 4'd4, ST_WB = 4'd5, ST_MA = 4'd6, ST_MM = 4'd7;
    localparam logic [3:0] ST_SD = 4'd8, ST_MW = 4'd9, ST_BR = 4'd10, ST_HALT = 4'd11;

    localparam int O_LDMDR = 0, O_TMDR = 1, O_LDMAR = 2, O_LDIR = 3, O_TLABEL = 4, O_ALUON = 5;
    localparam int O_MM = 6, O_LDALU = 7, O_LDSP = 8, O_LDPC = 9, O_TSP = 10, O_TPC = 11;
    localparam int O_LDREG = 12, O_TREG = 13, O_LDFLAG = 14, O_PCINC = 15, O_MDRBUS = 16;
    localparam int O_MEMRD = 17, O_MEMWR = 18, O_HALTED = 19, O_ILLEGAL = 20;

    logic [23:0] act_vec;
    assign act_vec = {fnSelect, illegal, halted, mem_wr, mem_rd, mdr_bus, pc_inc, ldFlag, Treg,
                      ldReg, Tpc, Tsp, ldPC, ldSP, ldALUreg, mm, ALUon, Tlabel, ldIR, ldMAR,
                      Tmdr, ldMDR};

    typedef struct {
        logic [3:0]  st;
        logic [23:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   fixed_wait = -1;
    int   max_wait = 3;

    function automatic logic [23:0] b(input int i);
        b = 24'd1 << i;
    endfunction

    function automatic logic [23:0] fa_vec();
        fa_vec = b(O_TPC) | b(O_LDMAR);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock cycle: drive inputs just after the edge and queue what the DUT must show.
    task automatic emit(input logic [3:0] st, input logic [23:0] vec, input logic mr,
                        input logic rst, input logic [3:0] op, input logic [2:0] f, input logic c);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        reset = rst;
        mem_ready = mr;
        if (st == ST_DEC || st == ST_EX || st == ST_WB || st == ST_MA) begin
            ir_1 = op;
            funct = f;
            cc = c;
        end else begin
            ir_1 = 4'($urandom);
            funct = 3'($urandom);
            cc = 1'($urandom);
        end
        e.st = st;
        e.vec = vec;
        exp_q.push_back(e);
        if (!rst) begin
            #1;
            chk("reset_async_state", 32'(state), 32'(ST_FA));
            chk("reset_async_mem_ld", 32'({mem_rd, mem_wr, ldMDR, ldReg}), 32'd0);
        end
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            emit(ST_FA, fa_vec(), 1'($urandom), 1'b0, 4'd0, 3'd0, 1'b0);
        end
    endtask

    // Memory wait phase: ok=0 when a reset aborted it.
    task automatic mem_phase(input logic [3:0] st, input logic [23:0] base, input logic ld_on_ready,
                             input logic force_abort, output logic ok);
        int w;
        w = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, max_wait);
        ok = 1'b1;
        for (int i = 0; i < w; i++) begin
            if ((force_abort && i == 1) || (fixed_wait < 0 && $urandom_range(0, 39) == 0)) begin
                reset_cycles($urandom_range(1, 2));
                ok = 1'b0;
                return;
            end
            emit(st, base, 1'b0, 1'b1, 4'd0, 3'd0, 1'b0);
        end
        emit(st, base | (ld_on_ready ? b(O_LDMDR) : 24'd0), 1'b1, 1'b1, 4'd0, 3'd0, 1'b0);
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [2:0] f, input logic c,
                             input logic force_abort);
        logic ok;
        logic legal;
        legal = (op <= 4'd5) || (op == 4'd15);
        emit(ST_FA, fa_vec(), 1'($urandom), 1'b1, op, f, c);
        mem_phase(ST_FM, b(O_MEMRD), 1'b1, 1'b0, ok);
        if (!ok) return;
        emit(ST_FI, b(O_TMDR) | b(O_LDIR) | b(O_PCINC), 1'($urandom), 1'b1, op, f, c);
        emit(ST_DEC, legal ? 24'd0 : b(O_ILLEGAL), 1'($urandom), 1'b1, op, f, c);
        case (op)
            4'd0, 4'd1: begin
                emit(ST_EX, {f, 21'd0} | b(O_ALUON) | b(O_LDALU) | b(O_LDFLAG) |
                     (op[0] ? b(O_MM) : 24'd0), 1'($urandom), 1'b1, op, f, c);
                emit(ST_WB, b(O_LDREG), 1'($urandom), 1'b1, op, f, c);
            end
            4'd2: begin
                emit(ST_MA, b(O_TLABEL) | b(O_LDMAR), 1'($urandom), 1'b1, op, f, c);
                mem_phase(ST_MM, b(O_MEMRD), 1'b1, force_abort, ok);
                if (ok) emit(ST_WB, b(O_LDREG) | b(O_TMDR), 1'($urandom), 1'b1, op, f, c);
            end
            4'd3: begin
                emit(ST_MA, b(O_TLABEL) | b(O_LDMAR), 1'($urandom), 1'b1, op, f, c);
                emit(ST_SD, b(O_TREG) | b(O_LDMDR) | b(O_MDRBUS), 1'($urandom), 1'b1, op, f, c);
                mem_phase(ST_MW, b(O_MEMWR), 1'b0, force_abort, ok);
            end
            4'd4: begin
                if (c) emit(ST_BR, b(O_TLABEL) | b(O_LDPC), 1'($urandom), 1'b1, op, f, c);
            end
            4'd5: begin
                emit(ST_BR, b(O_TLABEL) | b(O_LDPC), 1'($urandom), 1'b1, op, f, c);
            end
            4'd15: begin
                for (int i = 0; i < 20; i++) begin
                    emit(ST_HALT, b(O_HALTED), 1'($urandom), 1'b1, op, f, c);
                end
                reset_cycles(2);
            end
            default: begin
            end
        endcase
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("state_cyc%0d", cyc), 32'(state), 32'(e.st));
                chk($sformatf("outputs_cyc%0d_st%0d", cyc, e.st), 32'(act_vec), 32'(e.vec));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [3:0] ops [20];
        ops = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3,
                4'd4, 4'd4, 4'd4, 4'd5, 4'd5, 4'd6, 4'd9, 4'd12, 4'd14, 4'd15};
        #1;
        reset = 1'b0;
        #1;
        chk("reset_state", 32'(state), 32'(ST_FA));
        chk("reset_outputs", 32'(act_vec), 32'(fa_vec()));
        reset_cycles(2);

        fixed_wait = 0;
        run_instr(4'b0000, 3'b100, 1'b0, 1'b0);
        fixed_wait = 3;
        run_instr(4'b0010, 3'b000, 1'b0, 1'b0);
        fixed_wait = 0;
        run_instr(4'b0100, 3'b000, 1'b0, 1'b0);
        run_instr(4'b0100, 3'b000, 1'b1, 1'b0);
        run_instr(4'b1001, 3'b000, 1'b0, 1'b0);
        run_instr(4'b1111, 3'b000, 1'b0, 1'b0);
        run_instr(4'b0011, 3'b000, 1'b0, 1'b0);
        fixed_wait = 2;
        run_instr(4'b0011, 3'b000, 1'b0, 1'b1);

        fixed_wait = -1;
        for (int n = 0; n < 300; n++) begin
            run_instr(ops[$urandom_range(0, 19)], 3'($urandom), 1'($urandom), 1'b0);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: clk  input  1  single system clock, all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low; asserted (0) forces reset state immediately.
REQ-003 SHALL have ports: ir_1  input  4  opcode from datapath IR; funct  input  3  ALU function field; cc  input  1  condition flag from datapath.
REQ-004 SHALL have port: mem_ready  input  1  memory handshake, 1 = read data valid / write accepted this cycle.
REQ-005 SHALL have 1-bit outputs: ldMDR, Tmdr, ldMAR, ldIR, Tlabel, ALUon, mm, ldALUreg, ldSP, ldPC, Tsp, Tpc, ldReg, Treg, ldFlag, pc_inc, mdr_bus, mem_rd, mem_wr, halted, illegal.
REQ-006 SHALL have outputs: fnSelect  output  3  ALU function; state  output  4  current state code for debug.

Function
REQ-007 SHALL be a Moore FSM; outputs decode from state register only, except ldMDR in S_FM/S_MM, which is additionally gated by mem_ready.
REQ-008 SHALL implement states and codes: S_FA=0, S_FM=1, S_FI=2, S_DEC=3, S_EX=4, S_WB=5, S_MA=6, S_MM=7, S_SD=8, S_MW=9, S_BR=10, S_HALT=11; codes 12-15 SHALL go to S_FA next cycle.
REQ-009 S_FA: Tpc=1, ldMAR=1; next S_FM.
REQ-010 S_FM: mem_rd=1, ldMDR=mem_ready; stay while mem_ready=0, else S_FI.
REQ-011 S_FI: Tmdr=1, ldIR=1, pc_inc=1; next S_DEC.
REQ-012 S_DEC: all controls 0; next by ir_1: 0000/0001 -> S_EX; 0010/0011 -> S_MA; 0100 -> S_BR if cc=1 else S_FA; 0101 -> S_BR; 1111 -> S_HALT; any other -> S_FA with illegal=1 for that one cycle.
REQ-013 S_EX: ALUon=1, fnSelect=funct, mm=ir_1[0], ldALUreg=1, ldFlag=1; next S_WB.
REQ-014 S_WB: ldReg=1; Tmdr=1 when ir_1=0010, else ALU result path; next S_FA.
REQ-015 S_MA: Tlabel=1, ldMAR=1; next S_MM if ir_1=0010, S_SD if 0011.
REQ-016 S_MM: as S_FM (mem_rd=1, ldMDR=mem_ready); stay while mem_ready=0, else S_WB.
REQ-017 S_SD: Treg=1, ldMDR=1, mdr_bus=1; next S_MW.
REQ-018 S_MW: mem_wr=1; stay while mem_ready=0, else S_FA.
REQ-019 S_BR: Tlabel=1, ldPC=1; next S_FA.
REQ-020 S_HALT: halted=1, all other controls 0; SHALL remain until reset.
REQ-021 fnSelect SHALL be 000 and mm SHALL be 0 in every state except S_EX.
REQ-022 ldSP and Tsp SHALL be held 0 (reserved for stack ops); never asserted.
REQ-023 mem_rd and mem_wr SHALL never be 1 in the same cycle; at most one of Tpc, Tmdr, Tlabel, Treg, Tsp SHALL be 1 per cycle.
REQ-024 Latency with mem_ready=1 every cycle: ALU 6 cycles, load 7, store 7, branch taken/jump 5, branch not taken 4, illegal 4 (S_FA to next S_FA).
REQ-025 ir_1, funct, cc SHALL be sampled only in S_DEC/S_EX/S_WB/S_MA; changes elsewhere SHALL have no effect.

Reset
REQ-026 reset=0 SHALL asynchronously set state=S_FA and all outputs 0 except the S_FA decode (Tpc=1, ldMAR=1).
REQ-027 reset asserted mid-memory wait (S_FM/S_MM/S_MW) SHALL drop mem_rd/mem_wr within the same cycle with no ldMDR/ldReg pulse.
REQ-028 After reset release, first transition SHALL occur on the first rising clk edge with reset=1.

Verification
REQ-029 reset low then high, ir_1=0000, funct=100, mem_ready=1 -> states 0,1,2,3,4,5,0; S_EX shows fnSelect=100, ALUon=ldALUreg=ldFlag=1, mm=0.
REQ-030 ir_1=0010, mem_ready low for 3 cycles in S_MM -> S_MM held 4 cycles, mem_rd=1 throughout, ldMDR=1 only on the mem_ready cycle, then S_WB with Tmdr=ldReg=1.
REQ-031 ir_1=0100 with cc=0 -> S_DEC then S_FA, no ldPC; cc=1 -> S_BR with Tlabel=ldPC=1.
REQ-032 ir_1=1001 -> illegal=1 one cycle in S_DEC, return to S_FA; ir_1=1111 -> halted=1 held 20 cycles with all controls 0.
REQ-033 ir_1=0011, reset=0 asserted during S_MW -> mem_wr falls immediately, state=0, Tpc=ldMAR=1.
